// File: rtl/reaction_test_ctrl_pkg.sv
// Shared definitions for the reaction-time screen: state encoding (also decoded
// by the display mux), menu screen code and the delay LFSR step.
package reaction_test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GO    = 3'd3,
    ST_SHOW  = 3'd4,
    ST_EARLY = 3'd5,
    ST_CALC  = 3'd6,
    ST_DONE  = 3'd7
  } rt_state_e;

  localparam logic [1:0] MENU_REACT = 2'b01;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11; never reaches zero from a nonzero seed
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_test_ctrl_const_divider.sv
// Sequential restoring divider by a constant with start/busy/done handshake.
// One quotient bit per cycle; done pulses for one cycle after the last step.
module const_divider #(
  parameter int unsigned DIVIDEND_W = 17,
  parameter int unsigned DIVISOR    = 5,
  parameter int unsigned QUOT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int unsigned           STEPS = DIVIDEND_W - 1;
  localparam int unsigned           CNT_W = $clog2(STEPS);
  localparam logic [DIVIDEND_W:0]   DIV_C = (DIVIDEND_W + 1)'(DIVISOR);

  logic [DIVIDEND_W-1:0] rem;
  logic [STEPS-1:0]      dq;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W:0]   trial;

  assign trial    = {rem, dq[STEPS-1]};
  assign quotient = dq[QUOT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dq   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Dividend MSB is preloaded as the first partial remainder, saving one
        // step; exact whenever that bit is below DIVISOR (DIVISOR>=2 or MSB=0).
        rem  <= DIVIDEND_W'(dividend[DIVIDEND_W-1]);
        dq   <= dividend[STEPS-1:0];
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        if (trial >= DIV_C) begin
          rem <= DIVIDEND_W'(trial - DIV_C);
          dq  <= {dq[STEPS-2:0], 1'b1};
        end else begin
          rem <= trial[DIVIDEND_W-1:0];
          dq  <= {dq[STEPS-2:0], 1'b0};
        end
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(STEPS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-time benchmark sequencer: random wait, go, latency capture in ms,
// early-press detection and session average over ROUNDS valid rounds.
module reaction_test_ctrl
  import reaction_test_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 12,
  parameter int unsigned TIMEOUT_MS   = 9999
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iPress,
  output logic [2:0]  oCurState,
  output logic        oGo,
  output logic        oEarly,
  output logic [2:0]  oRound,
  output logic [13:0] oTimeMs,
  output logic [13:0] oAvgMs,
  output logic        oResultValid,
  output logic        oDone
);

  localparam int unsigned PRESC_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_MS - 1);
  localparam logic [13:0] TIMEOUT_C = 14'(TIMEOUT_MS);
  localparam logic [2:0]  ROUNDS_C  = 3'(ROUNDS);

  rt_state_e          state, state_nxt;
  logic [15:0]        lfsr;
  logic [PRESC_W-1:0] presc;
  logic [13:0]        ms_cnt;
  logic [13:0]        delay_ms;
  logic [2:0]         round;
  logic [16:0]        sum;
  logic [13:0]        time_ms;
  logic [13:0]        avg_ms;
  logic               result_valid;
  logic               go_q, early_q, done_q;
  logic               div_start, div_busy, div_done;
  logic [13:0]        div_quot;
  logic               timeout, delay_hit, entering;

  assign timeout   = (ms_cnt == TIMEOUT_C);
  assign delay_hit = (ms_cnt == delay_ms);
  assign entering  = (state_nxt != state);
  assign div_start = (state == ST_SHOW) && (state_nxt == ST_CALC);

  always_comb begin
    state_nxt = state;
    if (!iEnable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_ARMED;
        ST_ARMED: if (iPress) state_nxt = ST_WAIT;
        ST_WAIT:  if (iPress) state_nxt = ST_EARLY;
                  else if (delay_hit) state_nxt = ST_GO;
        ST_GO:    if (iPress || timeout) state_nxt = ST_SHOW;
        ST_SHOW:  if (iPress) state_nxt = (round == ROUNDS_C) ? ST_CALC : ST_WAIT;
        ST_EARLY: if (iPress) state_nxt = ST_WAIT;
        ST_CALC:  if (div_done && !div_busy) state_nxt = ST_DONE;
        ST_DONE:  if (iPress) state_nxt = ST_ARMED;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= ST_IDLE;
      lfsr         <= 16'hACE1;
      presc        <= '0;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      round        <= '0;
      sum          <= '0;
      time_ms      <= '0;
      avg_ms       <= '0;
      result_valid <= 1'b0;
      go_q         <= 1'b0;
      early_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      lfsr         <= lfsr16_next(lfsr);
      result_valid <= 1'b0;
      go_q         <= (state_nxt == ST_GO);
      early_q      <= (state_nxt == ST_EARLY);
      done_q       <= (state_nxt == ST_DONE);

      // ms timebase restarts on every entry into WAIT or GO
      if (entering && (state_nxt == ST_WAIT || state_nxt == ST_GO)) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (state == ST_WAIT || state == ST_GO) begin
        if (presc == PRESC_MAX) begin
          presc  <= '0;
          ms_cnt <= ms_cnt + 14'd1;
        end else begin
          presc <= presc + PRESC_W'(1);
        end
      end

      if (entering && state_nxt == ST_WAIT)
        delay_ms <= 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);

      if (!iEnable) begin
        round   <= '0;
        sum     <= '0;
        time_ms <= '0;
        avg_ms  <= '0;
      end else begin
        case (state)
          ST_ARMED: if (iPress) begin
            round <= 3'd1;
            sum   <= '0;
          end
          ST_GO: if (iPress || timeout) begin
            time_ms      <= iPress ? ms_cnt : TIMEOUT_C;
            sum          <= sum + 17'(iPress ? ms_cnt : TIMEOUT_C);
            result_valid <= 1'b1;
          end
          ST_SHOW: if (iPress && round != ROUNDS_C) round <= round + 3'd1;
          ST_CALC: if (div_done) avg_ms <= div_quot;
          ST_DONE: if (iPress) begin
            round <= '0;
            sum   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  const_divider #(
    .DIVIDEND_W (17),
    .DIVISOR    (ROUNDS),
    .QUOT_W     (14)
  ) u_div (
    .clk      (iClock),
    .rst      (iReset),
    .start    (div_start),
    .dividend (sum),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign oCurState    = state;
  assign oGo          = go_q;
  assign oEarly       = early_q;
  assign oRound       = round;
  assign oTimeMs      = time_ms;
  assign oAvgMs       = avg_ms;
  assign oResultValid = result_valid;
  assign oDone        = done_q;

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Directed bench for reaction_test_ctrl with small timing parameters:
// a vector table for the deterministic control path plus multi-cycle sequences.
module tb_reaction_test_ctrl;

  logic        clk = 1'b0;
  logic        iReset, iEnable, iPress;
  logic [2:0]  oCurState, oRound;
  logic        oGo, oEarly, oResultValid, oDone;
  logic [13:0] oTimeMs, oAvgMs;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_d    = 0;
  logic [15:0] m;

  reaction_test_ctrl #(
    .TICKS_PER_MS (4),
    .ROUNDS       (3),
    .MIN_DELAY_MS (2),
    .RAND_BITS    (2),
    .TIMEOUT_MS   (20)
  ) dut (
    .iClock       (clk),
    .iReset       (iReset),
    .iEnable      (iEnable),
    .iPress       (iPress),
    .oCurState    (oCurState),
    .oGo          (oGo),
    .oEarly       (oEarly),
    .oRound       (oRound),
    .oTimeMs      (oTimeMs),
    .oAvgMs       (oAvgMs),
    .oResultValid (oResultValid),
    .oDone        (oDone)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1
  always @(posedge clk) begin
    if (iReset) m <= 16'hACE1;
    else        m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic       press;
    logic [2:0] st;
    logic [2:0] rnd;
    logic [3:0] flags;   // {go, early, done, result_valid}
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic enter_wait(input int exp_round);
    exp_d = 2 + int'(m[1:0]);
    iPress = 1'b1;
    step();
    iPress = 1'b0;
    chk("wait_state", int'(oCurState), 2);
    chk("wait_round", int'(oRound), exp_round);
  endtask

  task automatic wait_go();
    int n = 0;
    while (oCurState == 3'd2 && n < 100) begin
      step();
      n++;
    end
    chk("go_state", int'(oCurState), 3);
    chk("go_delay_cycles", n, 4 * exp_d + 1);
    chk("go_flag", int'(oGo), 1);
  endtask

  task automatic react(input int k, input int exp_t);
    repeat (k) step();
    iPress = 1'b1;
    step();
    iPress = 1'b0;
    chk("show_state", int'(oCurState), 4);
    chk("time_ms", int'(oTimeMs), exp_t);
    chk("rv_high", int'(oResultValid), 1);
    step();
    chk("rv_pulse_end", int'(oResultValid), 0);
  endtask

  initial begin
    int n;
    iReset  = 1'b1;
    iEnable = 1'b0;
    iPress  = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 4'b0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd5, 3'd1, 4'b0100};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd5, 3'd1, 4'b0100};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 4'b0000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd2, 3'd1, 4'b0000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd2, 3'd1, 4'b0000};

    for (int i = 0; i < 13; i++) begin
      iReset  = vecs[i].rst;
      iEnable = vecs[i].en;
      iPress  = vecs[i].press;
      step();
      chk($sformatf("vec%0d_state", i), int'(oCurState), int'(vecs[i].st));
      chk($sformatf("vec%0d_round", i), int'(oRound), int'(vecs[i].rnd));
      chk($sformatf("vec%0d_flags", i), int'({oGo, oEarly, oDone, oResultValid}), int'(vecs[i].flags));
      chk($sformatf("vec%0d_stats", i), int'({oTimeMs, oAvgMs}), 0);
    end
    iPress = 1'b0;

    // Clean restart, then a full three-round session with one early press
    iEnable = 1'b0;
    step();
    iEnable = 1'b1;
    step();
    chk("rearm_state", int'(oCurState), 1);

    enter_wait(1);
    wait_go();
    react(13, 3);

    enter_wait(2);
    step();
    iPress = 1'b1;
    step();
    iPress = 1'b0;
    chk("early_state", int'(oCurState), 5);
    chk("early_flag", int'(oEarly), 1);
    chk("early_round", int'(oRound), 2);
    step();
    enter_wait(2);
    wait_go();
    react(20, 5);

    enter_wait(3);
    wait_go();
    react(32, 8);

    iPress = 1'b1;
    step();
    iPress = 1'b0;
    chk("calc_state", int'(oCurState), 6);
    chk("calc_round", int'(oRound), 3);
    n = 0;
    while (oCurState == 3'd6 && n < 40) begin
      iPress = (n == 5);
      step();
      n++;
    end
    iPress = 1'b0;
    chk("calc_cycles", n, 17);
    chk("done_state", int'(oCurState), 7);
    chk("done_flag", int'(oDone), 1);
    chk("avg_ms", int'(oAvgMs), 5);
    chk("time_hold_done", int'(oTimeMs), 8);

    iPress = 1'b1;
    step();
    iPress = 1'b0;
    chk("done_to_armed", int'(oCurState), 1);
    chk("armed_round", int'(oRound), 0);
    chk("avg_hold", int'(oAvgMs), 5);
    chk("done_flag_clr", int'(oDone), 0);

    // Timeout with no press, then a press in the exact timeout cycle
    enter_wait(1);
    wait_go();
    n = 0;
    while (oCurState == 3'd3 && n < 200) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 81);
    chk("timeout_state", int'(oCurState), 4);
    chk("timeout_time", int'(oTimeMs), 20);
    chk("timeout_rv", int'(oResultValid), 1);

    enter_wait(2);
    wait_go();
    react(80, 20);

    // Abort in GO with a simultaneous press
    enter_wait(3);
    wait_go();
    repeat (5) step();
    iEnable = 1'b0;
    iPress  = 1'b1;
    step();
    iPress  = 1'b0;
    chk("abort_state", int'(oCurState), 0);
    chk("abort_round", int'(oRound), 0);
    chk("abort_time", int'(oTimeMs), 0);
    chk("abort_avg", int'(oAvgMs), 0);
    chk("abort_go", int'(oGo), 0);
    chk("abort_rv", int'(oResultValid), 0);
    iEnable = 1'b1;
    step();
    chk("abort_rearm", int'(oCurState), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
